// File: rtl/sn74_mod_counter.sv
// sn74_mod_counter
// Parametrised synchronous presettable up/down counter with modulus,
// parallel load, count enable and cascade carry. Chaining cout into the
// next stage's cin, with shared clk/en/up/clr, builds wider synchronous
// counters (decade, BCD, arbitrary-modulus dividers).
module sn74_mod_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             cin,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             cout,
    output logic             wrap
);

    // Compare values are one bit wider than the counter so MODULUS = 2^WIDTH
    // (e.g. WIDTH=32) never overflows the terminal-value constant.
    localparam logic [WIDTH:0] C_MAX = (WIDTH+1)'(MODULUS - 64'sd1);

    // Reject illegal parameterisations at elaboration.
    if ((WIDTH < 1) || (WIDTH > 32) || (MODULUS < 2) ||
        (MODULUS > (64'sd1 <<< WIDTH))) begin : g_param_check
        $error("sn74_mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;

    logic [WIDTH:0]   w_out_ext;
    logic [WIDTH:0]   w_din_ext;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;

    assign w_out_ext = {1'b0, r_out};
    assign w_din_ext = {1'b0, din};
    assign w_at_max  = (w_out_ext == C_MAX);
    assign w_at_zero = (r_out == '0);

    // Terminal count follows up combinationally; cout gates it for cascading.
    assign w_tc = up ? w_at_max : w_at_zero;

    // Next value: load (clamped) > count > hold. Range checks use >= / >
    // so a deposited out-of-range value still lands inside 0..MODULUS-1.
    always_comb begin
        w_next      = r_out;
        w_wrap_next = 1'b0;
        if (load) begin
            w_next = (w_din_ext > C_MAX) ? C_MAX[WIDTH-1:0] : din;
        end else if (en && cin) begin
            if (up) begin
                if (w_out_ext >= C_MAX) begin
                    w_next      = '0;
                    w_wrap_next = w_at_max;
                end else begin
                    w_next = r_out + WIDTH'(1);
                end
            end else begin
                if (w_at_zero || (w_out_ext > C_MAX)) begin
                    w_next      = C_MAX[WIDTH-1:0];
                    w_wrap_next = w_at_zero;
                end else begin
                    w_next = r_out - WIDTH'(1);
                end
            end
        end
    end

    // State register; clr has top priority and also kills any wrap pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;
    assign tc   = w_tc;
    assign cout = w_tc && en && cin;

endmodule

// File: tb/tb_sn74_mod_counter.sv
// Scoreboard bench for sn74_mod_counter: a decade counter, a binary
// mod-16 counter, a two-stage decade cascade (0..99) and a 32-bit full-range
// counter all share the control inputs. The reference model keeps each as a
// plain integer with modular arithmetic.
module tb_sn74_mod_counter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        en = 1'b0;
    logic        cin = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  din = 4'd0;
    logic [31:0] din32 = 32'd0;

    logic [3:0]  out10, out16, lo_out, hi_out;
    logic        tc10, cout10, wrap10, tc16, cout16, wrap16;
    logic        lo_tc, lo_cout, lo_wrap, hi_tc, hi_cout, hi_wrap;
    logic [31:0] out32;
    logic        tc32, cout32, wrap32;

    always #5 clk = ~clk;

    sn74_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
        .clk(clk), .clr(clr), .en(en), .cin(cin), .up(up), .load(load), .din(din),
        .out(out10), .tc(tc10), .cout(cout10), .wrap(wrap10));

    sn74_mod_counter #(.WIDTH(4), .MODULUS(16)) u_bin (
        .clk(clk), .clr(clr), .en(en), .cin(cin), .up(up), .load(load), .din(din),
        .out(out16), .tc(tc16), .cout(cout16), .wrap(wrap16));

    sn74_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .clr(clr), .en(en), .cin(cin), .up(up), .load(load), .din(din),
        .out(lo_out), .tc(lo_tc), .cout(lo_cout), .wrap(lo_wrap));

    sn74_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .clr(clr), .en(en), .cin(lo_cout), .up(up), .load(load), .din(din),
        .out(hi_out), .tc(hi_tc), .cout(hi_cout), .wrap(hi_wrap));

    sn74_mod_counter #(.WIDTH(32), .MODULUS(64'sd4294967296)) u_w32 (
        .clk(clk), .clr(clr), .en(en), .cin(cin), .up(up), .load(load), .din(din32),
        .out(out32), .tc(tc32), .cout(cout32), .wrap(wrap32));

    typedef struct {
        longint o10; bit w10; bit t10; bit c10;
        longint o16; bit w16; bit t16; bit c16;
        longint o100; bit w100; bit c100;
        longint o32; bit w32; bit t32; bit c32;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint m10 = 0, m16 = 0, m100 = 0, m32 = 0;
    longint n_tx = 0;

    function automatic longint clampv(longint d, longint m);
        return (d < m) ? d : m - 1;
    endfunction

    // Behavioural rule: clear > load > count (mod m) > hold.
    function automatic longint nxt(longint v, longint m, bit c, bit l, bit e, bit ci,
                                   bit u, longint ld, output bit w);
        w = 1'b0;
        if (c) return 0;
        if (l) return ld;
        if (e && ci) begin
            if (u) begin
                if (v == m - 1) begin w = 1'b1; return 0; end
                return v + 1;
            end
            if (v == 0) begin w = 1'b1; return m - 1; end
            return v - 1;
        end
        return v;
    endfunction

    function automatic bit tcf(longint v, longint m, bit u);
        return u ? (v == m - 1) : (v == 0);
    endfunction

    task automatic chk(string name, longint act, longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s tx=%0d: got %0d expected %0d", name, n_tx, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus and push the expected post-edge response.
    task automatic step(bit c, bit l, bit e, bit ci, bit u, logic [3:0] d, logic [31:0] d32);
        exp_t x;
        bit   w;
        @(negedge clk);
        clr = c; load = l; en = e; cin = ci; up = u; din = d; din32 = d32;
        m10  = nxt(m10, 10, c, l, e, ci, u, clampv(longint'(d), 10), w);
        x.o10 = m10; x.w10 = w; x.t10 = tcf(m10, 10, u); x.c10 = x.t10 && e && ci;
        m16  = nxt(m16, 16, c, l, e, ci, u, clampv(longint'(d), 16), w);
        x.o16 = m16; x.w16 = w; x.t16 = tcf(m16, 16, u); x.c16 = x.t16 && e && ci;
        m100 = nxt(m100, 100, c, l, e, ci, u, clampv(longint'(d), 10) * 11, w);
        x.o100 = m100; x.w100 = w; x.c100 = tcf(m100, 100, u) && e && ci;
        m32  = nxt(m32, 64'sd4294967296, c, l, e, ci, u, longint'(d32), w);
        x.o32 = m32; x.w32 = w; x.t32 = tcf(m32, 64'sd4294967296, u); x.c32 = x.t32 && e && ci;
        sb.push_back(x);
    endtask

    // Monitor: one transaction per rising edge, sampled just after it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                n_tx++;
                chk("dec_out",  longint'(out10),  x.o10);
                chk("dec_wrap", longint'(wrap10), longint'(x.w10));
                chk("dec_tc",   longint'(tc10),   longint'(x.t10));
                chk("dec_cout", longint'(cout10), longint'(x.c10));
                chk("bin_out",  longint'(out16),  x.o16);
                chk("bin_wrap", longint'(wrap16), longint'(x.w16));
                chk("bin_tc",   longint'(tc16),   longint'(x.t16));
                chk("bin_cout", longint'(cout16), longint'(x.c16));
                chk("cas_val",  longint'(hi_out) * 16 + longint'(lo_out),
                                (x.o100 / 10) * 16 + (x.o100 % 10));
                chk("cas_wrap", longint'(hi_wrap), longint'(x.w100));
                chk("cas_cout", longint'(hi_cout), longint'(x.c100));
                chk("w32_out",  longint'(out32),  x.o32);
                chk("w32_wrap", longint'(wrap32), longint'(x.w32));
                chk("w32_tc",   longint'(tc32),   longint'(x.t32));
                chk("w32_cout", longint'(cout32), longint'(x.c32));
                $display("tx %0d: clr=%0b load=%0b en=%0b cin=%0b up=%0b din=%0d -> dec=%0d bin=%0d cas=%0d%0d w32=%0h",
                         n_tx, clr, load, en, cin, up, din, out10, out16, hi_out, lo_out, out32);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        bit          r_up;
        logic [31:0] d32;
        // Reset, held several cycles with counting requested (down: tc=1).
        repeat (3) step(1, 1, 1, 1, 0, 4'd5, 32'd5);
        // Binary wrap: 17 up edges.
        step(1, 0, 0, 1, 1, 4'd0, 32'd0);
        repeat (17) step(0, 0, 1, 1, 1, 4'd0, 32'd0);
        // Decade down from 3 across 0 -> 9.
        step(0, 1, 0, 1, 0, 4'd3, 32'd3);
        repeat (5) step(0, 0, 1, 1, 0, 4'd0, 32'd0);
        // Load clamp, load vs clear, load with en=0.
        step(0, 1, 1, 1, 1, 4'd12, 32'd12);
        step(1, 1, 1, 1, 1, 4'd7, 32'd7);
        step(0, 1, 0, 0, 1, 4'd6, 32'd6);
        // Load on what would be the wrap edge.
        step(0, 1, 0, 1, 1, 4'd9, 32'd9);
        step(0, 1, 1, 1, 1, 4'd4, 32'd4);
        // Cascade gating: at terminal count with cin=0, then resume.
        step(0, 1, 0, 1, 1, 4'd9, 32'd9);
        repeat (4) step(0, 0, 1, 0, 1, 4'd0, 32'd0);
        repeat (2) step(0, 0, 1, 1, 1, 4'd0, 32'd0);
        // Cascade 00..99..00, then 3 down.
        step(1, 0, 0, 1, 1, 4'd0, 32'd0);
        repeat (100) step(0, 0, 1, 1, 1, 4'd0, 32'd0);
        repeat (3) step(0, 0, 1, 1, 0, 4'd0, 32'd0);
        // Mid-count clear with load asserted, then release.
        step(1, 0, 0, 1, 1, 4'd0, 32'd0);
        repeat (7) step(0, 0, 1, 1, 1, 4'd0, 32'd0);
        repeat (2) step(1, 1, 1, 1, 1, 4'd5, 32'd5);
        step(0, 0, 1, 1, 1, 4'd0, 32'd0);
        // Randomized traffic.
        r_up = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) r_up = ~r_up;
            case ($urandom_range(0, 3))
                0:       d32 = 32'hFFFF_FFFF;
                1:       d32 = 32'h0000_0000;
                2:       d32 = 32'hFFFF_FFFE;
                default: d32 = $urandom;
            endcase
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                 r_up, 4'($urandom), d32);
        end
        repeat (2) @(negedge clk);
        chk("sb_drain", longint'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
